int_arbiter: RTL
================

INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 8, number of device interrupt sources.
REQ-002 Parameter PRIO_W, default 3, priority field width.
REQ-003 Parameter VECT_BASE, default 16'hFFC0, address of vector 0; each vector is 4 bytes (PSW word, entry-point word).
REQ-004 clock  in  1  single system clock; all logic on posedge; one clock, reset synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 irq  in  NUM_SRC  device interrupt request, level, sampled each clock.
REQ-007 src_prio  in  NUM_SRC*PRIO_W  priority of source i in bits [i*PRIO_W +: PRIO_W].
REQ-008 psw_prio  in  PRIO_W  current CPU priority from PSW.
REQ-009 inst_boundary  in  1  high when CPU may accept an interrupt, i.e. between instructions.
REQ-010 step_done  in  1  one-cycle pulse: current vector-entry step has completed.
REQ-011 E  out  1  enable to the vector-entry sequencer.
REQ-012 counter  out  4  vector-entry step index, 0..8.
REQ-013 vect_addr  out  16  VECT_BASE + 4*vect_num.
REQ-014 vect_num  out  4  index of the vector being serviced.
REQ-015 int_ack  out  1  one-cycle pulse on entry completion.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 pending[i] shall be set on any clock where irq[i]=1 and shall remain set after irq[i] deasserts.
REQ-018 pending[i] shall clear only on the int_ack cycle for vector i; if irq[i]=1 on that same cycle, set wins and the bit stays set.
REQ-019 Source i shall be eligible when pending[i]=1 and src_prio[i] > psw_prio, compared strictly and unsigned.
REQ-020 Among eligible sources, highest src_prio wins; on equal priority, the lowest index wins.
REQ-021 FSM states shall be IDLE, GRANT, ENTRY, ACK.
REQ-022 IDLE->GRANT: any source eligible and inst_boundary=1; the winner is registered into vect_num.
REQ-023 GRANT->ENTRY after exactly 1 cycle; vect_addr is valid from GRANT onward and held stable until back in IDLE.
REQ-024 ENTRY: E=1; counter starts at 0 and increments on each step_done.
REQ-025 step_done received with counter=8 shall move the FSM to ACK with E=0.
REQ-026 ACK: int_ack=1 for one cycle, the pending bit is cleared, and the FSM returns to IDLE.
REQ-027 Minimum latency from an eligible irq to E=1 shall be 3 clocks: latch, GRANT, ENTRY.
REQ-028 Requests arriving in GRANT, ENTRY or ACK shall be latched but not arbitrated until IDLE; no preemption of an entry in progress.
REQ-029 Changes to psw_prio or src_prio after GRANT shall not alter vect_num.
REQ-030 step_done in IDLE, GRANT or ACK shall be ignored.
REQ-031 counter shall be 0 whenever E=0.

Reset
REQ-032 On reset=1 at a clock edge: pending=0, state=IDLE, E=0, counter=0, vect_num=0, vect_addr=VECT_BASE, int_ack=0, busy=0.
REQ-033 Reset mid-ENTRY shall abort the sequence with no int_ack, and all pending requests shall be discarded.
REQ-034 Reset shall dominate irq on the same edge.

Configuration
REQ-035 Macro INT_ARB_NMI_EN: when defined, add input nmi (1 bit, level, latched like irq) as vector NUM_SRC, which wins over all sources regardless of psw_prio and still waits for inst_boundary.
REQ-036 When INT_ARB_NMI_EN is undefined, there is no nmi port and vect_num never exceeds NUM_SRC-1.

Structure
REQ-037 Shared package int_pkg shall hold the FSM state enum, VECT_BASE, the last-step constant 4'd8, and the PRIO_W default.
REQ-038 Combinational winner selection shall be sub-module int_prio_sel: inputs pending, src_prio, psw_prio (and nmi); outputs valid and index.

Verification
REQ-039 irq[2]=1 pulse, src_prio[2]=5, psw_prio=3, inst_boundary=1 -> E=1 on clock 3, vect_addr=16'hFFC8, vect_num=2.
REQ-040 irq[1] and irq[4] same cycle, both priority 4, psw_prio=0 -> vector 1 serviced first, vector 4 serviced after int_ack.
REQ-041 irq[0] priority 2, psw_prio=2 -> no grant; drop psw_prio to 1 -> grant vector 0.
REQ-042 9 step_done pulses in ENTRY -> counter 0..8 then int_ack pulse; pending[vect] cleared; busy=0 the next cycle.
REQ-043 reset asserted with counter=5 -> next cycle E=0, counter=0, no int_ack, pending=0.
REQ-044 With INT_ARB_NMI_EN: nmi=1, irq[7] priority 7, psw_prio=7 -> vect_num=8, vect_addr=16'hFFE0.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM encoding, vector
// table base, last vector-entry step index and default priority width.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ENTRY = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [15:0] VECT_BASE      = 16'hFFC0;
    localparam logic [3:0]  LAST_STEP      = 4'd8;
    localparam int          PRIO_W_DEFAULT = 3;
    localparam int          IDX_W          = 4;

endpackage

// File: rtl/int_prio_sel.sv
// Combinational winner select: highest priority above psw_prio, lowest index on ties.
// Latency: zero cycles (pure combinational).
// Backpressure: none; optional nmi input (INT_ARB_NMI_EN) overrides all sources.
module int_prio_sel #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = int_pkg::PRIO_W_DEFAULT
) (
    input  logic [NUM_SRC-1:0]         pending,
    input  logic [NUM_SRC*PRIO_W-1:0]  src_prio,
    input  logic [PRIO_W-1:0]          psw_prio,
`ifdef INT_ARB_NMI_EN
    input  logic                       nmi,
`endif
    output logic                       valid,
    output logic [int_pkg::IDX_W-1:0]  index
);
    import int_pkg::*;

    logic [PRIO_W-1:0] best_prio;

    always_comb begin
        valid     = 1'b0;
        index     = '0;
        best_prio = '0;
        // Strict '>' against best_prio keeps the lowest index on equal priority.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && (src_prio[i*PRIO_W +: PRIO_W] > psw_prio) &&
                (!valid || (src_prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
                valid     = 1'b1;
                index     = IDX_W'(i);
                best_prio = src_prio[i*PRIO_W +: PRIO_W];
            end
        end
`ifdef INT_ARB_NMI_EN
        if (nmi) begin
            valid = 1'b1;
            index = IDX_W'(NUM_SRC);
        end
`endif
    end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: latches level irqs, picks a winner at instruction boundaries, runs a 9-step vector entry.
// Latency: 3 clocks from irq to E (latch, GRANT, ENTRY); int_ack one cycle after the 9th step_done.
// Backpressure: entry advances only on step_done; new requests wait in pending until IDLE. Macro INT_ARB_NMI_EN adds nmi.
module int_arbiter #(
    parameter int          NUM_SRC   = 8,
    parameter int          PRIO_W    = int_pkg::PRIO_W_DEFAULT,
    parameter logic [15:0] VECT_BASE = int_pkg::VECT_BASE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         irq,
    input  logic [NUM_SRC*PRIO_W-1:0]  src_prio,
    input  logic [PRIO_W-1:0]          psw_prio,
    input  logic                       inst_boundary,
    input  logic                       step_done,
`ifdef INT_ARB_NMI_EN
    input  logic                       nmi,
`endif
    output logic                       E,
    output logic [3:0]                 counter,
    output logic [15:0]                vect_addr,
    output logic [3:0]                 vect_num,
    output logic                       int_ack,
    output logic                       busy
);
    import int_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_SRC-1:0] pending;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_index;
    logic               grant_go;

`ifdef INT_ARB_NMI_EN
    logic nmi_pend;

    always_ff @(posedge clock) begin
        if (reset) begin
            nmi_pend <= 1'b0;
        end else begin
            nmi_pend <= nmi | (nmi_pend & ~(int_ack && (vect_num == IDX_W'(NUM_SRC))));
        end
    end
`endif

    int_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_prio_sel (
        .pending  (pending),
        .src_prio (src_prio),
        .psw_prio (psw_prio),
`ifdef INT_ARB_NMI_EN
        .nmi      (nmi_pend),
`endif
        .valid    (sel_valid),
        .index    (sel_index)
    );

    assign grant_go = (state == IDLE) && sel_valid && inst_boundary;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_valid && inst_boundary) state_nxt = GRANT;
            GRANT:   state_nxt = ENTRY;
            ENTRY:   if (step_done && (counter == LAST_STEP)) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        E       = 1'b0;
        int_ack = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            GRANT:   busy = 1'b1;
            ENTRY: begin
                busy = 1'b1;
                E    = 1'b1;
            end
            ACK: begin
                busy    = 1'b1;
                int_ack = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // A new irq on the ack cycle wins over the clear, so the bit stays set.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                pending[i] <= irq[i] | (pending[i] & ~(int_ack && (vect_num == IDX_W'(i))));
            end
        end
    end

    // vect_num is captured once in IDLE so later psw/src priority changes cannot move it.
    always_ff @(posedge clock) begin
        if (reset) begin
            vect_num <= '0;
        end else if (grant_go) begin
            vect_num <= sel_index;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= '0;
        end else if (state == ENTRY) begin
            if (step_done) begin
                counter <= (counter == LAST_STEP) ? 4'd0 : counter + 4'd1;
            end
        end else begin
            counter <= '0;
        end
    end

    assign vect_addr = VECT_BASE + (16'(vect_num) << 2);

endmodule
